fetch_pc_unit: RTL

//  Front-end fetch stage of the 3-stage core. Holds the PC and chooses next PC
//  (sequential, taken-branch target, jump target). Drives the synchronous-read

---
 rtl/fetch_pc_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch stage PC unit: holds the PC, selects the next fetch address
// (sequential / branch / jump / held redirect), drives the IMEM address, and
// presents PC, instruction and valid to decode.
module fetch_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_br_targ,
    input  logic            i_jump,
    input  logic [XLEN-1:0] i_jump_targ,
    input  logic            i_stall,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [31:0]     i_imem_rdata,
    output logic [XLEN-1:0] o_if_pc,
    output logic [31:0]     o_if_inst,
    output logic            o_if_valid,
    output logic            o_misalign
);

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_pend_vld;
    logic [XLEN-1:0] r_pend_targ;
    logic            r_misalign;

    logic            w_redir_req;
    logic [XLEN-1:0] w_redir_targ;
    logic [XLEN-1:0] w_pc_next;
    logic            w_apply;
    logic [XLEN-1:0] w_apply_targ;
    logic            w_if_valid;

    // Incoming redirect this cycle; jump outranks a taken branch and has
    // bit 0 cleared for JALR.
    assign w_redir_req  = i_jump | i_br_taken;
    assign w_redir_targ = i_jump ? (i_jump_targ & JALR_MASK) : i_br_targ;

    // Next-PC selection and kill decision.
    always_comb begin
        w_pc_next    = r_pc;
        w_apply      = 1'b0;
        w_apply_targ = w_redir_targ;
        w_if_valid   = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_pc_next = RESET_PC;
            end
            default: begin
                // A held redirect or a redirect arriving now makes the word
                // at r_pc wrong-path.
                w_if_valid = ~r_pend_vld & ~w_redir_req;
                if (!i_stall) begin
                    if (r_pend_vld) begin
                        w_apply      = 1'b1;
                        w_apply_targ = r_pend_targ;
                    end else if (w_redir_req) begin
                        w_apply      = 1'b1;
                        w_apply_targ = w_redir_targ;
                    end
                    w_pc_next = w_apply ? w_apply_targ : (r_pc + PC_STEP);
                end
                // While stalled the same word is re-read so it stays
                // available when decode resumes.
            end
        endcase
    end

    // PC, FSM, pending-redirect and sticky misalign state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_PC - PC_STEP;
            r_pend_vld  <= 1'b0;
            r_pend_targ <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN:  r_state <= i_stall ? ST_HOLD : ST_RUN;
                ST_HOLD: r_state <= i_stall ? ST_HOLD : ST_RUN;
                default: r_state <= ST_BOOT;
            endcase
            if (r_state != ST_BOOT) begin
                if (i_stall) begin
                    // Last redirect seen during a stall is the one kept.
                    if (w_redir_req) begin
                        r_pend_vld  <= 1'b1;
                        r_pend_targ <= w_redir_targ;
                    end
                end else begin
                    r_pend_vld <= 1'b0;
                end
            end
            if (w_apply && w_apply_targ[1]) begin
                r_misalign <= 1'b1;
            end
        end
    end

    assign o_imem_addr = w_pc_next;
    assign o_if_pc     = r_pc;
    assign o_if_valid  = w_if_valid;
    assign o_if_inst   = w_if_valid ? i_imem_rdata : NOP_INST;
    assign o_misalign  = r_misalign;

endmodule
